// File: rtl/panel_fb_ctrl.sv
// panel_fb_ctrl: 16x8 LED frame buffer plus a UART byte-command sequencer (WRITE/FILL/ROTATE/CLEAR).
// Optional macro FB_ROTATE_EN builds frame-synchronous auto-rotation; without it opcode 10 is ignored.
module panel_fb_ctrl #(
  parameter int NCOL = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       frame_done,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       overflow
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_ROT   = 2'b10;
  localparam logic [3:0] COL_LAST = 4'(NCOL - 1);

`ifdef FB_ROTATE_EN
  typedef enum logic [1:0] {S_IDLE, S_GET_DATA, S_FILL, S_ROTATE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_GET_DATA, S_FILL} state_e;
`endif

  state_e     state_q;
  logic [3:0] col_q;
  logic [3:0] wr_col_q;
  logic       fill_bit_q;
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] hold_dat_q, hold_dat_d;
  logic       busy_q;
  logic       overflow_q;
  logic       ovf_set;
  logic [7:0] fb_q [NCOL];

  logic       byte_avail;
  logic [7:0] cur_byte;
  logic       seq_last;

  // A held byte is older than anything on rx_byte, so it always goes first.
  assign byte_avail = hold_vld_q | rx_valid;
  assign cur_byte   = hold_vld_q ? hold_dat_q : rx_byte;
  assign seq_last   = (col_q == COL_LAST);

  assign rd_data  = fb_q[rd_col];
  assign busy     = busy_q;
  assign overflow = overflow_q;

  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    ovf_set    = 1'b0;
    if (state_q == S_IDLE || state_q == S_GET_DATA) begin
      // Any held byte is consumed this cycle, so a fresh byte may take its slot.
      hold_vld_d = hold_vld_q & rx_valid;
      if (hold_vld_q && rx_valid) begin
        hold_dat_d = rx_byte;
      end
    end else if (rx_valid) begin
      if (hold_vld_q) begin
        ovf_set = 1'b1;
      end else begin
        hold_vld_d = 1'b1;
        hold_dat_d = rx_byte;
      end
    end
  end

`ifdef FB_ROTATE_EN
  logic auto_q;
  logic dir_q;
  logic pend_q, pend_d;
  logic rot_start;

  assign rot_start = (state_q == S_IDLE) && !byte_avail && pend_q;

  always_comb begin
    pend_d = (pend_q && !rot_start) || (frame_done && auto_q);
    if (state_q == S_IDLE && byte_avail && cur_byte[7:6] == OP_ROT && !cur_byte[0]) begin
      pend_d = 1'b0;
    end
  end

  function automatic logic [7:0] rot8(input logic [7:0] b, input logic left);
    return left ? {b[6:0], b[7]} : {b[0], b[7:1]};
  endfunction
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      wr_col_q   <= '0;
      fill_bit_q <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NCOL; i++) begin
        fb_q[i] <= '0;
      end
`ifdef FB_ROTATE_EN
      auto_q <= 1'b0;
      dir_q  <= 1'b0;
      pend_q <= 1'b0;
`endif
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end
`ifdef FB_ROTATE_EN
      pend_q <= pend_d;
`endif
      case (state_q)
        S_IDLE: begin
          if (byte_avail) begin
            case (cur_byte[7:6])
              OP_WRITE: begin
                wr_col_q <= cur_byte[3:0];
                state_q  <= S_GET_DATA;
              end
              OP_FILL: begin
                fill_bit_q <= cur_byte[0];
                col_q      <= '0;
                busy_q     <= 1'b1;
                state_q    <= S_FILL;
              end
              OP_ROT: begin
`ifdef FB_ROTATE_EN
                auto_q <= cur_byte[0];
                dir_q  <= cur_byte[1];
`endif
              end
              default: overflow_q <= 1'b0;
            endcase
          end
`ifdef FB_ROTATE_EN
          else if (rot_start) begin
            col_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ROTATE;
          end
`endif
        end
        S_GET_DATA: begin
          if (byte_avail) begin
            fb_q[wr_col_q] <= cur_byte;
            state_q        <= S_IDLE;
          end
        end
        S_FILL: begin
          fb_q[col_q] <= {8{fill_bit_q}};
          col_q       <= col_q + 4'd1;
          if (seq_last) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
`ifdef FB_ROTATE_EN
        S_ROTATE: begin
          fb_q[col_q] <= rot8(fb_q[col_q], dir_q);
          col_q       <= col_q + 4'd1;
          if (seq_last) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_fb_ctrl.sv
// Scoreboard bench for panel_fb_ctrl: stimulus queues expected reads and busy-run lengths, monitors compare.
`timescale 1ns/1ps
module tb_panel_fb_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       frame_done = 1'b0;
  logic [3:0] rd_col = 4'h0;
  logic [7:0] rd_data;
  logic       busy;
  logic       overflow;

  int total = 0;
  int bad = 0;

  typedef enum int {K_RD, K_BUSY, K_OVF} kind_e;
  typedef struct {
    kind_e      kind;
    logic [3:0] col;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t rd_q[$];
  int   busy_len_q[$];

  always #5 clk = ~clk;

  panel_fb_ctrl #(.NCOL(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .frame_done(frame_done),
    .rd_col    (rd_col),
    .rd_data   (rd_data),
    .busy      (busy),
    .overflow  (overflow)
  );

  function automatic void chk(input kind_e k, input logic [3:0] col, input logic [7:0] e, input string n);
    chk_t c;
    c.kind = k;
    c.col  = col;
    c.exp  = e;
    c.name = n;
    rd_q.push_back(c);
  endfunction

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1 rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1 rx_valid = 1'b0;
  endtask

  task automatic pulse_fd();
    @(posedge clk); #1 frame_done = 1'b1;
    @(posedge clk); #1 frame_done = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && rd_q.size() > 0; i++) @(posedge clk);
    total++;
    if (rd_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d checks left unserviced, required 0", rd_q.size());
      rd_q.delete();
    end
  endtask

  // Read/flag monitor: one queued check per cycle, sampled mid-cycle.
  initial begin : mon
    chk_t c;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (rd_q.size() > 0) begin
        c = rd_q.pop_front();
        if (c.kind == K_RD) rd_col = c.col;
        #1;
        case (c.kind)
          K_RD:    act = rd_data;
          K_BUSY:  act = {7'b0, busy};
          default: act = {7'b0, overflow};
        endcase
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s[%0d]: got %02h, required %02h", c.name, c.col, act, c.exp);
        end
      end
    end
  end

  // Busy monitor: each completed busy run is checked against the next expected length.
  initial begin : bmon
    int run;
    int e;
    run = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        total++;
        if (busy_len_q.size() == 0) begin
          bad++;
          $display("FAIL busy_run: got %0d cycles, required no run", run);
        end else begin
          e = busy_len_q.pop_front();
          if (run != e) begin
            bad++;
            $display("FAIL busy_run: got %0d cycles, required %0d", run, e);
          end
        end
        run = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    for (int i = 0; i < 16; i++) chk(K_RD, 4'(i), 8'h00, "reset_col");
    chk(K_BUSY, 4'h0, 8'h00, "reset_busy");
    chk(K_OVF,  4'h0, 8'h00, "reset_ovf");
    drain();

    // Single-column write, visible the cycle after the data byte
    send(8'h05);
    send(8'hA5);
    chk(K_RD, 4'h5, 8'hA5, "write_col5");
    chk(K_RD, 4'h4, 8'h00, "write_col4");
    chk(K_RD, 4'h6, 8'h00, "write_col6");
    chk(K_BUSY, 4'h0, 8'h00, "write_busy");
    drain();

    // Fill ones, then fill zeros
    busy_len_q.push_back(16);
    send(8'h41);
    repeat (20) @(posedge clk);
    for (int i = 0; i < 16; i++) chk(K_RD, 4'(i), 8'hFF, "fill1_col");
    drain();
    busy_len_q.push_back(16);
    send(8'h40);
    repeat (20) @(posedge clk);
    for (int i = 0; i < 16; i++) chk(K_RD, 4'(i), 8'h00, "fill0_col");
    drain();

    // Holding register and overflow during a fill
    busy_len_q.push_back(16);
    send(8'h41);
    send(8'h03);
    send(8'h44);
    chk(K_OVF,  4'h0, 8'h01, "ovf_set");
    chk(K_BUSY, 4'h0, 8'h01, "ovf_busy");
    repeat (20) @(posedge clk);
    send(8'h5A);
    chk(K_RD, 4'h3, 8'h5A, "held_write_col3");
    chk(K_RD, 4'h2, 8'hFF, "dropped_fill_col2");
    chk(K_OVF, 4'h0, 8'h01, "ovf_sticky");
    drain();
    send(8'hC0);
    chk(K_OVF, 4'h0, 8'h00, "ovf_clear");
    drain();

`ifdef FB_ROTATE_EN
    // Rotate right
    send(8'h00);
    send(8'h01);
    send(8'h81);
    busy_len_q.push_back(16);
    pulse_fd();
    repeat (20) @(posedge clk);
    chk(K_RD, 4'h0, 8'h80, "rotr_col0");
    chk(K_RD, 4'h3, 8'h2D, "rotr_col3");
    chk(K_RD, 4'h9, 8'hFF, "rotr_col9");
    drain();

    // Rotate left
    send(8'h00);
    send(8'h01);
    send(8'h83);
    busy_len_q.push_back(16);
    pulse_fd();
    repeat (20) @(posedge clk);
    chk(K_RD, 4'h0, 8'h02, "rotl_col0");
    chk(K_RD, 4'h3, 8'h5A, "rotl_col3");
    drain();

    // Byte and frame_done together: write completes, then one rotate
    busy_len_q.push_back(16);
    @(posedge clk); #1 rx_valid = 1'b1; rx_byte = 8'h07; frame_done = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0; frame_done = 1'b0;
    send(8'h11);
    repeat (22) @(posedge clk);
    chk(K_RD, 4'h7, 8'h22, "simul_col7");
    chk(K_RD, 4'h0, 8'h04, "simul_col0");
    chk(K_RD, 4'h3, 8'hB4, "simul_col3");
    drain();

    // Auto-rotate disabled: frame_done has no effect
    send(8'h80);
    pulse_fd();
    repeat (20) @(posedge clk);
    chk(K_RD, 4'h0, 8'h04, "autooff_col0");
    chk(K_BUSY, 4'h0, 8'h00, "autooff_busy");
    drain();
`else
    // Rotate opcode ignored and frame_done unused; next byte is a fresh command
    send(8'h81);
    pulse_fd();
    send(8'h06);
    send(8'h77);
    repeat (20) @(posedge clk);
    chk(K_RD, 4'h6, 8'h77, "norot_col6");
    chk(K_RD, 4'h0, 8'hFF, "norot_col0");
    chk(K_RD, 4'h3, 8'h5A, "norot_col3");
    chk(K_BUSY, 4'h0, 8'h00, "norot_busy");
    drain();
`endif

    // Reset in the middle of a fill
    busy_len_q.push_back(5);
    send(8'h41);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 16; i++) chk(K_RD, 4'(i), 8'h00, "midreset_col");
    chk(K_BUSY, 4'h0, 8'h00, "midreset_busy");
    chk(K_OVF,  4'h0, 8'h00, "midreset_ovf");
    drain();
    repeat (25) @(posedge clk);

    total++;
    if (busy_len_q.size() != 0) begin
      bad++;
      $display("FAIL busy_runs_missing: got %0d runs outstanding, required 0", busy_len_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
